// File: rtl/poly_user_pkg.sv
// Shared types and bit maps for the PolyPlay user-port joystick path:
// SNES serial bit order on one side, joystick_0 bit layout on the other.
package poly_user_pkg;

  typedef enum logic [2:0] {
    UJR_IDLE,
    UJR_LATCH,
    UJR_SETTLE,
    UJR_CLK_LO,
    UJR_CLK_HI,
    UJR_DONE
  } ujr_state_t;

  // Position of each button in the pad's serial stream.
  localparam int SNES_B      = 0;
  localparam int SNES_Y      = 1;
  localparam int SNES_SELECT = 2;
  localparam int SNES_START  = 3;
  localparam int SNES_UP     = 4;
  localparam int SNES_DOWN   = 5;
  localparam int SNES_LEFT   = 6;
  localparam int SNES_RIGHT  = 7;
  localparam int SNES_A      = 8;
  localparam int SNES_X      = 9;
  localparam int SNES_L      = 10;
  localparam int SNES_R      = 11;

  // joystick_0 bit positions, also used by the OR-merge in emu.
  localparam int JOY_RIGHT  = 0;
  localparam int JOY_LEFT   = 1;
  localparam int JOY_DOWN   = 2;
  localparam int JOY_UP     = 3;
  localparam int JOY_A      = 4;
  localparam int JOY_B      = 5;
  localparam int JOY_X      = 6;
  localparam int JOY_Y      = 7;
  localparam int JOY_L      = 8;
  localparam int JOY_R      = 9;
  localparam int JOY_SELECT = 10;
  localparam int JOY_START  = 11;

  localparam int JOY_BTN_W  = 12;

  function automatic logic [JOY_BTN_W-1:0] snes_to_joy(input logic [15:0] raw);
    logic [JOY_BTN_W-1:0] joy;
    joy             = '0;
    joy[JOY_RIGHT]  = raw[SNES_RIGHT];
    joy[JOY_LEFT]   = raw[SNES_LEFT];
    joy[JOY_DOWN]   = raw[SNES_DOWN];
    joy[JOY_UP]     = raw[SNES_UP];
    joy[JOY_A]      = raw[SNES_A];
    joy[JOY_B]      = raw[SNES_B];
    joy[JOY_X]      = raw[SNES_X];
    joy[JOY_Y]      = raw[SNES_Y];
    joy[JOY_L]      = raw[SNES_L];
    joy[JOY_R]      = raw[SNES_R];
    joy[JOY_SELECT] = raw[SNES_SELECT];
    joy[JOY_START]  = raw[SNES_START];
    return joy;
  endfunction

endpackage

// File: rtl/pp_sync2.sv
// Generic two-flop synchroniser for asynchronous user-port inputs.
module pp_sync2 #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: non-blocking assignments make both flops sample the pre-edge value,
  // keeping this a true two-stage pipeline rather than a single wire.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/user_port_joy_rx.sv
// Polls a SNES-style serial pad on the user port and presents a debounced
// joystick word in the joystick_0 layout, plus a frame strobe and fault flag.
module user_port_joy_rx
  import poly_user_pkg::*;
#(
  parameter int HALF_CYC = 300,
  parameter int POLL_CYC = 833333
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [6:0]  USER_IN,
  output logic [6:0]  USER_OUT,
  output logic [31:0] joy_out,
  output logic        joy_valid,
  output logic        pad_fault
);

  localparam int HCNT_W = $clog2(2 * HALF_CYC);
  localparam int POLL_W = $clog2(POLL_CYC);

  localparam logic [HCNT_W-1:0] HALF_LAST  = HCNT_W'(HALF_CYC - 1);
  localparam logic [HCNT_W-1:0] LATCH_LAST = HCNT_W'(2 * HALF_CYC - 1);
  localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_CYC - 1);

  ujr_state_t state_q, state_d;

  logic [HCNT_W-1:0]    half_cnt;
  logic [POLL_W-1:0]    poll_cnt;
  logic [3:0]           bit_idx;
  logic [15:0]          raw;
  logic [JOY_BTN_W-1:0] joy_btn;
  logic [JOY_BTN_W-1:0] joy_prev;
  logic [JOY_BTN_W-1:0] joy_mapped;

  logic pad_data;
  logic phase_end;
  logic latch_pin;
  logic clock_pin;
  logic frame_start;
  logic sample_en;

  // Only pin 5 is an input to this block; the rest belong to other users.
  logic unused_user_in;
  assign unused_user_in = ^{USER_IN[6], USER_IN[4:0]};

  pp_sync2 #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk_sys (clk_sys),
    .reset   (reset),
    .d       (USER_IN[5]),
    .q       (pad_data)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) state_q <= UJR_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_d     = state_q;
    phase_end   = 1'b0;
    latch_pin   = 1'b0;
    clock_pin   = 1'b1;
    joy_valid   = 1'b0;
    frame_start = 1'b0;
    unique case (state_q)
      UJR_IDLE: begin
        frame_start = (poll_cnt == POLL_LAST);
        if (frame_start) state_d = UJR_LATCH;
      end
      UJR_LATCH: begin
        latch_pin = 1'b1;
        phase_end = (half_cnt == LATCH_LAST);
        if (phase_end) state_d = UJR_SETTLE;
      end
      UJR_SETTLE: begin
        phase_end = (half_cnt == HALF_LAST);
        if (phase_end) state_d = UJR_CLK_LO;
      end
      UJR_CLK_LO: begin
        clock_pin = 1'b0;
        phase_end = (half_cnt == HALF_LAST);
        if (phase_end) state_d = UJR_CLK_HI;
      end
      UJR_CLK_HI: begin
        phase_end = (half_cnt == HALF_LAST);
        if (phase_end) state_d = (bit_idx == 4'd15) ? UJR_DONE : UJR_CLK_LO;
      end
      UJR_DONE: begin
        joy_valid = 1'b1;
        state_d   = UJR_IDLE;
      end
      default: state_d = UJR_IDLE;
    endcase
  end

  // Bit 0 arrives right after the latch; bits 1..15 follow each clock rise.
  assign sample_en  = phase_end && ((state_q == UJR_SETTLE) || (state_q == UJR_CLK_HI));
  assign joy_mapped = snes_to_joy(raw);

  // NOTE: the raw frame buffer is reset along with the control state so a
  // frame cut short by reset can never leak stale bits into a later DONE.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      poll_cnt  <= POLL_LAST;
      half_cnt  <= '0;
      bit_idx   <= '0;
      raw       <= '0;
      joy_btn   <= '0;
      joy_prev  <= '0;
      pad_fault <= 1'b0;
    end else begin
      poll_cnt <= frame_start ? '0 : poll_cnt + POLL_W'(1);

      if ((state_d != state_q) || (state_q == UJR_IDLE) || (state_q == UJR_DONE))
        half_cnt <= '0;
      else
        half_cnt <= half_cnt + HCNT_W'(1);

      if (frame_start) begin
        bit_idx <= '0;
        raw     <= '0;
      end else if (sample_en) begin
        raw[bit_idx] <= ~pad_data;
        bit_idx      <= bit_idx + 4'd1;
      end

      if (state_q == UJR_DONE) begin
        if (raw == 16'hFFFF) begin
          // Data line held low for the whole frame: no pad or a shorted pin.
          pad_fault <= 1'b1;
          joy_btn   <= '0;
          joy_prev  <= '0;
        end else begin
          pad_fault <= 1'b0;
          if (joy_mapped == joy_prev) joy_btn <= joy_mapped;
          joy_prev <= joy_mapped;
        end
      end
    end
  end

  assign USER_OUT = {5'b11111, clock_pin, latch_pin};
  assign joy_out  = {{(32 - JOY_BTN_W){1'b0}}, joy_btn};

endmodule

// File: tb/tb_user_port_joy_rx.sv
// Directed bench for user_port_joy_rx with a behavioural SNES pad on the user port.
module tb_user_port_joy_rx;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [6:0]  USER_IN;
  logic [6:0]  USER_OUT;
  logic [31:0] joy_out;
  logic        joy_valid;
  logic        pad_fault;

  int n_cmp = 0;
  int n_err = 0;
  logic upper_ok = 1'b1;

  // Pad model: pressed buttons by raw index, shift position, stuck-low switch.
  logic [15:0] pad_btn = 16'h0000;
  logic [3:0]  pad_idx = 4'd0;
  logic        tie_low = 1'b0;
  logic        pad_pin;
  logic        mdl_latch_q = 1'b0;
  logic        mdl_clock_q = 1'b1;

  always #5 clk_sys = ~clk_sys;

  user_port_joy_rx #(
    .HALF_CYC (4),
    .POLL_CYC (200)
  ) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .USER_IN   (USER_IN),
    .USER_OUT  (USER_OUT),
    .joy_out   (joy_out),
    .joy_valid (joy_valid),
    .pad_fault (pad_fault)
  );

  // Latch rise reloads bit 0; each clock rise shifts out the next bit.
  always @(negedge clk_sys) begin
    if (USER_OUT[0] && !mdl_latch_q)      pad_idx = 4'd0;
    else if (USER_OUT[1] && !mdl_clock_q) pad_idx = pad_idx + 4'd1;
    mdl_latch_q = USER_OUT[0];
    mdl_clock_q = USER_OUT[1];
  end

  assign pad_pin = tie_low ? 1'b0 : ~pad_btn[pad_idx];
  assign USER_IN = {1'b1, pad_pin, 5'b11111};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_sys);
    if (USER_OUT[6:2] !== 5'b11111) upper_ok = 1'b0;
  endtask

  // Leaves the bench on the DONE cycle.
  task automatic wait_valid();
    int n;
    n = 0;
    while (!joy_valid && n < 400) begin
      step();
      n++;
    end
    check("valid_seen", {31'd0, joy_valid}, 32'd1);
  endtask

  task automatic frame();
    wait_valid();
    step();
  endtask

  initial begin
    int latch_hi, clk_lo, clk_fall, valid_cnt, valid_t, next_latch_t, n;
    logic prev_lat, prev_clk;

    reset   = 1'b1;
    pad_btn = 16'h0110;  // A (raw 8) + Up (raw 4)
    repeat (3) step();
    check("rst_user_out", {25'd0, USER_OUT}, 32'h7E);
    check("rst_joy_out", joy_out, 32'h0);
    check("rst_joy_valid", {31'd0, joy_valid}, 32'd0);
    check("rst_pad_fault", {31'd0, pad_fault}, 32'd0);

    // Frame timing, counted from the first edge after reset release.
    reset = 1'b0;
    latch_hi = 0; clk_lo = 0; clk_fall = 0; valid_cnt = 0; valid_t = 0; next_latch_t = 0;
    prev_lat = 1'b0; prev_clk = 1'b1;
    for (int t = 1; t <= 201; t++) begin
      step();
      if (t == 1) check("latch_cycle1", {25'd0, USER_OUT}, 32'h7F);
      if (t <= 200) begin
        if (USER_OUT[0]) latch_hi++;
        if (!USER_OUT[1]) clk_lo++;
        if (!USER_OUT[1] && prev_clk) clk_fall++;
        if (joy_valid) begin
          valid_cnt++;
          if (valid_t == 0) valid_t = t;
        end
      end
      if (t > 1 && USER_OUT[0] && !prev_lat && next_latch_t == 0) next_latch_t = t;
      if (t == 134) begin
        check("f1_joy_mismatch_hold", joy_out, 32'h0);
        check("f1_pad_fault", {31'd0, pad_fault}, 32'd0);
      end
      prev_lat = USER_OUT[0];
      prev_clk = USER_OUT[1];
    end
    check("latch_width", 32'(latch_hi), 32'd8);
    check("clock_pulses", 32'(clk_fall), 32'd15);
    check("clock_low_cycles", 32'(clk_lo), 32'd60);
    check("valid_after_latch", 32'(valid_t - 1), 32'd132);
    check("valid_width", 32'(valid_cnt), 32'd1);
    check("poll_period", 32'(next_latch_t - 1), 32'd200);

    // Second identical frame: debounce accepts A+Up.
    wait_valid();
    check("f2_joy_on_done", joy_out, 32'h0);
    step();
    check("f2_joy_stable", joy_out, 32'h18);

    // B and Y alternate every frame: never stable, so the old word holds.
    pad_btn = 16'h0001;
    frame();
    check("alt_b_hold", joy_out, 32'h18);
    pad_btn = 16'h0002;
    frame();
    check("alt_y_hold", joy_out, 32'h18);
    pad_btn = 16'h0001;
    frame();
    check("alt_b2_hold", joy_out, 32'h18);

    // Data line stuck low, then released with nothing pressed.
    tie_low = 1'b1;
    wait_valid();
    check("fault_on_done_old", {31'd0, pad_fault}, 32'd0);
    step();
    check("fault_set", {31'd0, pad_fault}, 32'd1);
    check("fault_joy_zero", joy_out, 32'h0);
    tie_low = 1'b0;
    pad_btn = 16'h0000;
    frame();
    check("fault_clear", {31'd0, pad_fault}, 32'd0);
    check("fault_clear_joy", joy_out, 32'h0);

    // All twelve buttons held.
    pad_btn = 16'h0FFF;
    frame();
    check("all_first_frame", joy_out, 32'h0);
    frame();
    check("all_stable", joy_out, 32'hFFF);
    check("all_no_fault", {31'd0, pad_fault}, 32'd0);

    // Reset pulse in the middle of a clock-low phase.
    n = 0;
    while (!USER_OUT[0] && n < 300) begin
      step();
      n++;
    end
    check("latch_before_reset", {31'd0, USER_OUT[0]}, 32'd1);
    repeat (45) step();
    check("mid_frame_clk_lo", {31'd0, USER_OUT[1]}, 32'd0);
    reset = 1'b1;
    step();
    check("midrst_user_out", {25'd0, USER_OUT}, 32'h7E);
    check("midrst_joy_out", joy_out, 32'h0);
    check("midrst_joy_valid", {31'd0, joy_valid}, 32'd0);
    reset = 1'b0;
    step();
    check("midrst_relatch", {25'd0, USER_OUT}, 32'h7F);

    // History was cleared by reset, so two more frames are needed.
    frame();
    check("post_rst_first", joy_out, 32'h0);
    frame();
    check("post_rst_stable", joy_out, 32'hFFF);

    check("user_out_upper_high", {31'd0, upper_ok}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
